// File: rtl/decode_issue_if.sv
// Handshake and register-bank port bundle between the decode/issue stage and its neighbours.
// The slave modport is the stage's view; master is the upstream/execute/writeback side.
interface decode_issue_if #(
    parameter int unsigned dir = 4,
    parameter int unsigned iw  = 32
);
    logic            in_valid;
    logic [iw-1:0]   in_instr;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic            re;
    logic [dir-1:0]  da;
    logic [dir-1:0]  db;
    logic [dir-1:0]  dc;
    logic [dir-1:0]  wr_addr;
    logic            wr_en;
    logic [3:0]      cond;
    logic [1:0]      cls;
    logic            wb_valid;
    logic [dir-1:0]  wb_addr;
    logic            flush;

    modport master (
        output in_valid, in_instr, out_ready, wb_valid, wb_addr, flush,
        input  in_ready, out_valid, re, da, db, dc, wr_addr, wr_en, cond, cls
    );

    modport slave (
        input  in_valid, in_instr, out_ready, wb_valid, wb_addr, flush,
        output in_ready, out_valid, re, da, db, dc, wr_addr, wr_en, cond, cls
    );
endinterface

// File: rtl/decode_issue.sv
// ARMv4 decode-and-issue stage: single holding register, combinational decode of bank read
// addresses, and a pending-write scoreboard that stalls read-after-write hazards.
module decode_issue #(
    parameter int unsigned dir = 4,
    parameter int unsigned iw  = 32
) (
    input logic          clk,
    input logic          rst_n,
    decode_issue_if.slave bus
);
    localparam int unsigned NREG   = 1 << dir;
    localparam logic [dir-1:0] PC_REG = dir'(15);
    localparam logic [dir-1:0] LR_REG = dir'(14);

    logic            hold_valid;
    logic [iw-1:0]   hold_instr;
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    logic [dir-1:0]  da_c, db_c, dc_c, wa_c;
    logic            use_a, use_b, use_c, en_c;
    logic [1:0]      cls_c;
    logic [3:0]      cond_c;
    logic [3:0]      opcode;
    logic            hazard, issue, accept;
    logic            unused_bits;

    assign opcode      = hold_instr[24:21];
    assign unused_bits = ^hold_instr[7:5];

    // Decode the held word; everything reads as 0 while nothing is held.
    always_comb begin
        da_c   = '0;
        db_c   = '0;
        dc_c   = '0;
        wa_c   = '0;
        use_a  = 1'b0;
        use_b  = 1'b0;
        use_c  = 1'b0;
        en_c   = 1'b0;
        cls_c  = 2'b00;
        cond_c = 4'h0;
        if (hold_valid) begin
            cls_c  = hold_instr[27:26];
            cond_c = hold_instr[31:28];
            unique case (hold_instr[27:26])
                2'b00: begin
                    use_a = 1'b1;
                    use_b = 1'b1;
                    da_c  = dir'(hold_instr[19:16]);
                    db_c  = dir'(hold_instr[3:0]);
                    if (!hold_instr[25] && hold_instr[4]) begin
                        use_c = 1'b1;
                        dc_c  = dir'(hold_instr[11:8]);
                    end
                    // TST/TEQ/CMP/CMN only update flags
                    if (!(opcode >= 4'b1000 && opcode <= 4'b1011)) begin
                        en_c = 1'b1;
                        wa_c = dir'(hold_instr[15:12]);
                    end
                end
                2'b01: begin
                    use_a = 1'b1;
                    da_c  = dir'(hold_instr[19:16]);
                    if (hold_instr[25]) begin
                        use_b = 1'b1;
                        db_c  = dir'(hold_instr[3:0]);
                    end
                    if (!hold_instr[20]) begin
                        use_c = 1'b1;
                        dc_c  = dir'(hold_instr[15:12]);
                    end else begin
                        en_c = 1'b1;
                        wa_c = dir'(hold_instr[15:12]);
                    end
                end
                2'b10: begin
                    if (hold_instr[24]) begin
                        en_c = 1'b1;
                        wa_c = LR_REG;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // R15 reads never stall; only the registered scoreboard is consulted.
    assign hazard = (use_a && (da_c != PC_REG) && pending[da_c])
                  | (use_b && (db_c != PC_REG) && pending[db_c])
                  | (use_c && (dc_c != PC_REG) && pending[dc_c]);

    assign issue  = hold_valid & ~hazard & bus.out_ready;
    assign accept = bus.in_valid & bus.in_ready;

    assign bus.out_valid = hold_valid & ~hazard;
    assign bus.re        = issue & ~bus.flush;
    assign bus.in_ready  = (~hold_valid | issue) & ~bus.flush;
    assign bus.da        = da_c;
    assign bus.db        = db_c;
    assign bus.dc        = dc_c;
    assign bus.wr_addr   = wa_c;
    assign bus.wr_en     = en_c;
    assign bus.cond      = cond_c;
    assign bus.cls       = cls_c;

    // Set is applied after clear so a same-cycle set wins; flush overrides both.
    always_comb begin
        pending_nxt = pending;
        if (bus.wb_valid && (bus.wb_addr != PC_REG)) begin
            pending_nxt[bus.wb_addr] = 1'b0;
        end
        if (bus.re && en_c && (wa_c != PC_REG)) begin
            pending_nxt[wa_c] = 1'b1;
        end
        if (bus.flush) begin
            pending_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_instr <= '0;
            pending    <= '0;
        end else begin
            pending <= pending_nxt;
            if (bus.flush) begin
                hold_valid <= 1'b0;
            end else if (accept) begin
                hold_valid <= 1'b1;
                hold_instr <= bus.in_instr;
            end else if (issue) begin
                hold_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/decode_issue.md
# decode_issue

Decode-and-issue stage directly upstream of the CPU register bank. It accepts one 32-bit ARMv4 instruction word per handshake and extracts the bank read addresses (`da`, `db`, `dc`) and the destination address. A 16-entry pending-write scoreboard stalls read-after-write hazards. It drives the bank's read-enable on issue and hands the decoded instruction to execute one cycle behind the bank read.

## Interface
Parameters:
- `dir`, 4: register address width; the bank holds 2**dir registers.
- `iw`, 32: instruction word width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream instruction valid.
- `in_instr`  in  iw  instruction word.
- `in_ready`  out  1  stage can accept this cycle.
- `out_valid`  out  1  decoded instruction issuable (no hazard).
- `out_ready`  in  1  execute accepts.
- `re`  out  1  bank read enable; equals `out_valid & out_ready`.
- `da`, `db`, `dc`  out  dir  bank read addresses.
- `wr_addr`  out  dir  destination register.
- `wr_en`  out  1  instruction writes `wr_addr`.
- `cond`  out  4  `instr[31:28]` passthrough.
- `cls`  out  2  class: 00 data-processing (DP), 01 load/store (LS), 10 branch, 11 undefined.
- `wb_valid`  in  1  writeback commit this cycle.
- `wb_addr`  in  dir  register being committed.
- `flush`  in  1  kill the held instruction and clear the scoreboard.

## Operation
- Holding register (`hold_valid`, instruction) decoded combinationally. Outputs `da/db/dc/wr_addr/wr_en/cond/cls` are valid whenever `hold_valid` is 1.
- Decode by `instr[27:26]`:
  - DP:
    - `da`=Rn[19:16], `db`=Rm[3:0].
    - `dc`=Rs[11:8], used only when `instr[25]`=0 and `instr[4]`=1.
    - `wr_en`=1 with `wr_addr`=Rd[15:12], except opcodes 1000–1011 (TST/TEQ/CMP/CMN), which have `wr_en`=0.
  - LS:
    - `da`=Rn; `db`=Rm, used only when `instr[25]`=1.
    - Store (`instr[20]`=0): `dc`=Rd, used; `wr_en`=0.
    - Load: `wr_en`=1, `wr_addr`=Rd.
  - Branch: no sources used. BL (`instr[24]`=1) gives `wr_en`=1, `wr_addr`=14.
  - Undefined: no sources, `wr_en`=0. Issues normally.
- Unused address outputs drive 0.
- `hazard` = any used source `s` with `s`≠15 and `pending[s]`=1. R15 reads never stall.
- `out_valid` = `hold_valid & ~hazard`.
- `issue` = `out_valid & out_ready`.
- `in_ready` = `~hold_valid | issue`.
- On issue with `wr_en` and `wr_addr`≠15, set `pending[wr_addr]`.
- On `wb_valid` with `wb_addr`≠15, clear `pending[wb_addr]`.
- Set and clear of the same bit in the same cycle: set wins.
- `flush`:
  - Clears `hold_valid` and all `pending` bits on the next edge.
  - Overrides any simultaneous accept, issue or wb.
  - Forces `in_ready`=0 and `re`=0 that cycle.

## Timing
- Reset (async, `rst_n`=0):
  - `hold_valid`=0 and `pending`=0, so `out_valid`=0, `re`=0 and `in_ready`=1.
  - Decoded outputs are 0 (held instruction reset to 0).
- Latency: an instruction accepted at edge *t* is issuable in cycle *t*+1. The bank samples `da/db/dc` at that issue edge; `doa/dob/doc` are valid one cycle after issue.
- Back-to-back accept and issue sustains 1 instruction per cycle when there are no hazards.
- Hazard check uses the registered `pending` only. A wb commit at edge *t* unblocks issue in cycle *t*+1; there is no same-cycle bypass.
- The held instruction is stable while `hold_valid` & ~`issue`.
- Reset asserted mid-stall drops the instruction and the scoreboard immediately.

## Test plan
- Reset: `rst_n`=0 mid-stream → `out_valid`=0, `re`=0, `in_ready`=1, `pending`=0.
- 0xE0821003 (ADD R1,R2,R3) then 0xE0414005 (SUB R4,R1,R5), `out_ready`=1:
  - ADD issues with `da`=2, `db`=3, `wr_addr`=1, `re`=1.
  - SUB holds `out_valid`=0 and `in_ready`=0 until `wb_valid`/`wb_addr`=1.
  - SUB issues the cycle after that commit with `da`=1, `db`=5.
- 0xE1520003 (CMP R2,R3) → `wr_en`=0; a following read of R0 does not stall.
- 0xE5910000 (LDR R0,[R1]) → `cls`=01, `da`=1, `wr_addr`=0, `wr_en`=1. 0xEB000010 (BL) → `cls`=10, `wr_addr`=14.
- Stalled SUB from scenario 2 plus `flush`=1 → next cycle `hold_valid`=0, `pending`=0; a new SUB accepted then issues without stall.
- `wb_valid` for R1 in the same cycle as ADD R1 issues → `pending[1]` remains 1.
